// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
//   state_t    : game FSM states
//   LFSR_SEED  : LFSR value after reset
//   SCORE_MAX  : saturation ceiling of the 6-bit score
//   LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   lfsr_next  : one Fibonacci shift step
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    COOLDOWN,
    OVER
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [5:0]  SCORE_MAX = 6'd63;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/switch_edge_detect.sv
// Two-flop synchroniser followed by an edge register.
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input bits
//   edges      : one-cycle pulse per bit; rising edges only when RISE_ONLY,
//                otherwise either edge. Pulses 2 cycles after the pin change
//                so the consumer acts on the 3rd edge.
module switch_edge_detect #(
  parameter int W         = 16,
  parameter bit RISE_ONLY = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] edges
);

  logic [W-1:0] s1, s2, q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      q  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      q  <= s2;
    end
  end

  assign edges = RISE_ONLY ? (s2 & ~q) : (s2 ^ q);

endmodule

// File: rtl/whack_game_controller.sv
// Whack-a-mole game sequencer: starts a round on BTNC, lights one
// pseudo-random mole at a time, scores switch toggles on the lit position,
// and counts down the round in seconds.
//   CLK, RST_N : clock, async active-low reset
//   BTNC       : start button (async, pre-debounced)
//   SWITCHES   : whack inputs (async), a toggle either way is a whack
//   LEDS       : one-hot mole position or zero
//   SCORE      : hits this round, saturating at 63
//   TIME_LEFT  : seconds remaining in the round
//   PLAYING    : high in SPAWN/UP/COOLDOWN
//   GAME_OVER  : high in OVER
// Optional macro MISS_PENALTY_EN: a whack on an unlit bit while a mole is up
// (with no simultaneous hit) takes one point off, floored at zero.
module whack_game_controller
  import whack_pkg::*;
#(
  parameter int SEC_CYCLES       = 100_000_000,
  parameter int GAME_SECONDS     = 60,
  parameter int MOLE_CYCLES_INIT = 75_000_000,
  parameter int MOLE_CYCLES_MIN  = 25_000_000,
  parameter int MOLE_STEP        = 2_500_000,
  parameter int COOLDOWN_CYCLES  = 10_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BTNC,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic [5:0]  SCORE,
  output logic [7:0]  TIME_LEFT,
  output logic        PLAYING,
  output logic        GAME_OVER
);

  state_t      state, state_nxt;
  logic        start;
  logic [15:0] whack;
  logic [15:0] lfsr;
  logic [15:0] leds;
  logic [5:0]  score;
  logic [7:0]  time_left;
  logic [31:0] sec_cnt;
  logic [31:0] tmr;       // mole lifetime in UP, dark gap in COOLDOWN
  logic [31:0] lifetime;
  logic [3:0]  cur_idx;   // also serves as "previous mole" for SPAWN
  logic [3:0]  spawn_idx;

  logic playing, start_round, sec_tick, time_done, hit, mole_exp;

  switch_edge_detect #(.W(1), .RISE_ONLY(1'b1)) u_btn (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (BTNC),
    .edges (start)
  );

  switch_edge_detect #(.W(16), .RISE_ONLY(1'b0)) u_sw (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (SWITCHES),
    .edges (whack)
  );

  assign playing     = (state == SPAWN) || (state == UP) || (state == COOLDOWN);
  assign start_round = ((state == IDLE) || (state == OVER)) && start;
  assign sec_tick    = playing && (sec_cnt == 32'(SEC_CYCLES - 1));
  assign time_done   = sec_tick && (time_left == 8'd1);
  assign hit         = (state == UP) && whack[cur_idx];
  assign mole_exp    = (state == UP) && (tmr == 32'd1);
  // Never light the same position twice in a row.
  assign spawn_idx   = (lfsr[3:0] == cur_idx) ? lfsr[3:0] + 4'd1 : lfsr[3:0];

`ifdef MISS_PENALTY_EN
  logic miss;
  assign miss = (state == UP) && (|whack) && !hit;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OVER: if (start) state_nxt = SPAWN;
      SPAWN:      state_nxt = UP;
      UP:         if (hit || mole_exp) state_nxt = COOLDOWN;
      COOLDOWN:   if (tmr == 32'd1) state_nxt = SPAWN;
      default:    state_nxt = IDLE;
    endcase
    // Running out of time overrides anything else that happens this cycle.
    if (time_done) state_nxt = OVER;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr      <= LFSR_SEED;
      leds      <= '0;
      score     <= '0;
      time_left <= 8'(GAME_SECONDS);
      sec_cnt   <= '0;
      tmr       <= '0;
      lifetime  <= 32'(MOLE_CYCLES_INIT);
      cur_idx   <= '0;
    end else begin
      // Free-running, so positions depend on when the player acts.
      lfsr <= lfsr_next(lfsr);
      if (start_round) begin
        leds      <= '0;
        score     <= '0;
        time_left <= 8'(GAME_SECONDS);
        sec_cnt   <= '0;
        lifetime  <= 32'(MOLE_CYCLES_INIT);
      end else if (playing) begin
        sec_cnt <= sec_tick ? 32'd0 : sec_cnt + 32'd1;
        if (sec_tick) time_left <= time_left - 8'd1;
        if (time_done) begin
          leds <= '0;
        end else begin
          case (state)
            SPAWN: begin
              cur_idx <= spawn_idx;
              leds    <= 16'd1 << spawn_idx;
              tmr     <= lifetime;
            end
            UP: begin
              if (hit) begin
                leds  <= '0;
                tmr   <= 32'(COOLDOWN_CYCLES);
                score <= (score == SCORE_MAX) ? score : score + 6'd1;
                if (lifetime >= 32'(MOLE_CYCLES_MIN + MOLE_STEP))
                  lifetime <= lifetime - 32'(MOLE_STEP);
                else
                  lifetime <= 32'(MOLE_CYCLES_MIN);
              end else if (mole_exp) begin
                leds <= '0;
                tmr  <= 32'(COOLDOWN_CYCLES);
              end else begin
                tmr <= tmr - 32'd1;
`ifdef MISS_PENALTY_EN
                if (miss && (score != 6'd0)) score <= score - 6'd1;
`endif
              end
            end
            COOLDOWN: tmr <= tmr - 32'd1;
            default: ;
          endcase
        end
      end
    end
  end

  assign LEDS      = leds;
  assign SCORE     = score;
  assign TIME_LEFT = time_left;
  assign PLAYING   = playing;
  assign GAME_OVER = (state == OVER);

endmodule

// File: doc/whack_game_controller.md
Name: whack_game_controller

Overview:
Game sequencer for the whack-a-mole datapath. Starts a round on BTNC, selects mole positions pseudo-randomly and drives the 16 LEDs. Detects whacks as toggles on the 16 slide switches, keeps the score and the countdown of seconds remaining, and ends the game. Its SCORE and TIME_LEFT outputs feed the existing binary-to-BCD / seven-segment display path.

Parameters:
SEC_CYCLES, 100_000_000, CLK cycles per game second
GAME_SECONDS, 60, round length in seconds (1..255)
MOLE_CYCLES_INIT, 75_000_000, initial mole-up lifetime in cycles
MOLE_CYCLES_MIN, 25_000_000, floor on mole lifetime
MOLE_STEP, 2_500_000, lifetime reduction per hit
COOLDOWN_CYCLES, 10_000_000, dark gap between moles

Ports:
CLK  in  1  system clock, all logic rising-edge
RST_N  in  1  asynchronous active-low reset
BTNC  in  1  start button, pre-debounced, asynchronous to CLK
SWITCHES  in  16  whack inputs, asynchronous to CLK
LEDS  out  16  one-hot mole position, or zero
SCORE  out  6  hits this round, saturating
TIME_LEFT  out  8  seconds remaining
PLAYING  out  1  high in SPAWN/UP/COOLDOWN
GAME_OVER  out  1  high in OVER

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RST_N). Reset values: LEDS=0, SCORE=0, TIME_LEFT=GAME_SECONDS, PLAYING=0, GAME_OVER=0, state IDLE, LFSR=16'hACE1, lifetime=MOLE_CYCLES_INIT. Reset during play aborts the round immediately.
- Input synchronisation: BTNC and SWITCHES each pass through 2-flop synchronisers, then one edge register.
  - Start = rising edge of synchronised BTNC.
  - Whack on bit i = either edge on synchronised SWITCHES[i].
  - Detection occurs 3 cycles after the pin change.
- States:
  - IDLE: LEDS=0. On start → SPAWN; clear SCORE; TIME_LEFT=GAME_SECONDS; reset the second counter and lifetime.
  - SPAWN: 1 cycle. idx = LFSR[3:0]. If idx equals the previous mole index, use idx+1 mod 16. Set LEDS=1<<idx, load the mole timer with the lifetime → UP.
  - UP: hit (whack on idx) → LEDS=0 next cycle, SCORE+1 (saturates at 63), lifetime -= MOLE_STEP (floored at MOLE_CYCLES_MIN) → COOLDOWN. Mole timer expiry → LEDS=0 → COOLDOWN, no score change.
  - COOLDOWN: LEDS=0 for COOLDOWN_CYCLES → SPAWN.
  - OVER: LEDS=0, GAME_OVER=1, SCORE and TIME_LEFT hold. On start → same action as from IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states, so mole position depends on player timing.
- Second counter: runs only while PLAYING. Every SEC_CYCLES cycles TIME_LEFT decrements. When TIME_LEFT reaches 0 → OVER on the same cycle the decrement commits.
- Simultaneous events:
  - Time expiry and a hit in the same cycle: expiry wins, no score.
  - Hit and mole-timer expiry in the same cycle: hit wins.
  - Several switches toggling in one cycle: a hit if the lit bit is among them; other toggles are ignored.
- BTNC while PLAYING is ignored. Whacks in IDLE, COOLDOWN and OVER are ignored.

Optional Feature:
MISS_PENALTY_EN.
- Defined: in UP, a whack on any unlit bit with no simultaneous hit decrements SCORE (saturates at 0); the mole stays up.
- Undefined: misses have no effect.

Decomposition:
- Package whack_pkg: state enum (IDLE, SPAWN, UP, COOLDOWN, OVER), LFSR_SEED=16'hACE1, SCORE_MAX=63, LFSR tap mask.
- One sub-module, switch_edge_detect: parameterised width, 2-flop synchroniser plus edge register. Instantiated for SWITCHES (16) and BTNC (1).

Test Plan:
All tests use SEC_CYCLES=100, GAME_SECONDS=3, MOLE_CYCLES_INIT=50, MOLE_CYCLES_MIN=20, MOLE_STEP=10, COOLDOWN_CYCLES=5.
1. Reset with RST_N low, then release → LEDS=0, SCORE=0, TIME_LEFT=3, PLAYING=0. Toggle switches in IDLE → no change.
2. BTNC pulse → PLAYING rises; exactly one LEDS bit is set about 4 cycles later. Never whack → every mole clears after 50 cycles. TIME_LEFT steps 3,2,1,0 at 100-cycle intervals. GAME_OVER=1 and SCORE=0 at the end.
3. Toggle the lit switch → LEDS=0 within 4 cycles of the pin change, SCORE=1, the next mole lifetime is 40 cycles. After 3 further hits the lifetime stays at 20.
4. Toggle the lit switch on the same cycle the last second expires → GAME_OVER=1, SCORE unchanged.
5. With MISS_PENALTY_EN: score 2, then toggle an unlit switch → SCORE=1, mole stays lit. At SCORE=0 a miss keeps SCORE=0. Without the macro a miss leaves SCORE=2.
6. Assert RST_N mid-UP → all outputs return to reset values asynchronously. BTNC in OVER → new round starts with SCORE=0, TIME_LEFT=3. Two consecutive moles never share an index over 200 spawns.
